// File: rtl/pkt_mem_pkg.sv
// Shared types for the two-bank packet buffer.
// Bank state encoding and bank count.
package pkt_mem_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } bank_st_e;

    localparam int NUM_BANKS = 2;

endpackage

// File: rtl/packet_pingpong_mem_if.sv
// Snooper write bus and filter read handshake of the packet buffer.
// master = snooper/reader side, slave = buffer side.
interface packet_pingpong_mem_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  done;
    logic                  mem_ready;
    logic                  pkt_avail;
    logic [ADDR_WIDTH:0]   pkt_len;
    logic                  pkt_trunc;
    logic                  rd_start;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_done;

    modport master (
        output wr_addr, wr_data, wr_en, done,
        output rd_start, rd_addr, rd_en, rd_done,
        input  mem_ready, pkt_avail, pkt_len, pkt_trunc,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_addr, wr_data, wr_en, done,
        input  rd_start, rd_addr, rd_en, rd_done,
        output mem_ready, pkt_avail, pkt_len, pkt_trunc,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/pkt_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Storage is never reset so it maps onto block RAM.
module pkt_dpram #(
    parameter int DW = 64,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/packet_pingpong_mem.sv
// Two-bank ping-pong packet buffer between the stream snooper and the filter.
// Packets are delivered in arrival order; the snooper is stalled when both banks are full.
module packet_pingpong_mem
    import pkt_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    packet_pingpong_mem_if.slave bus
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    localparam logic [LW-1:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    bank_st_e               r_st      [NUM_BANKS];
    bank_st_e               w_st_nxt  [NUM_BANKS];
    logic [LW-1:0]          r_len     [NUM_BANKS];
    logic [LW-1:0]          w_len_nxt [NUM_BANKS];
    logic [NUM_BANKS-1:0]   r_trunc;
    logic [NUM_BANKS-1:0]   w_trunc_nxt;
    logic                   r_wr_sel;
    logic                   w_wr_sel_nxt;
    logic                   r_rd_sel;
    logic                   w_rd_sel_nxt;
    logic                   r_rd_valid;

    logic                   w_mem_ready;
    logic                   w_wr_acc;
    logic                   w_close;
    logic                   w_ram_we;
    logic                   w_rd_ok;
    logic                   w_claim;
    logic                   w_release;
    logic                   w_avail;
    logic [DATA_WIDTH-1:0]  w_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_st[b]  <= FREE;
                r_len[b] <= '0;
            end
            r_trunc    <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_st       <= w_st_nxt;
            r_len      <= w_len_nxt;
            r_trunc    <= w_trunc_nxt;
            r_wr_sel   <= w_wr_sel_nxt;
            r_rd_sel   <= w_rd_sel_nxt;
            r_rd_valid <= w_rd_ok;
        end
    end

    // Writer and reader never own the same bank in one cycle, so both
    // updates can be applied per bank without arbitration.
    always_comb begin
        w_st_nxt     = r_st;
        w_len_nxt    = r_len;
        w_trunc_nxt  = r_trunc;
        w_wr_sel_nxt = r_wr_sel;
        w_rd_sel_nxt = r_rd_sel;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_wr_acc && r_wr_sel == 1'(b)) begin
                if (bus.done) begin
                    w_st_nxt[b]  = READY;
                    w_len_nxt[b] = r_trunc[b] ? FULL
                                 : {1'b0, bus.wr_addr} + LW'(1);
                end else begin
                    if (r_st[b] == FREE) begin
                        w_st_nxt[b]    = WRITING;
                        w_trunc_nxt[b] = 1'b0;
                    end
                    if (bus.wr_addr == LAST) begin
                        w_trunc_nxt[b] = 1'b1;
                    end
                end
            end
            if (r_rd_sel == 1'(b)) begin
                if (w_claim) begin
                    w_st_nxt[b] = READING;
                end
                if (w_release) begin
                    w_st_nxt[b]    = FREE;
                    w_trunc_nxt[b] = 1'b0;
                end
            end
        end
        if (w_close) begin
            w_wr_sel_nxt = ~r_wr_sel;
        end
        if (w_release) begin
            w_rd_sel_nxt = ~r_rd_sel;
        end
    end

    always_comb begin
        w_mem_ready = (r_st[r_wr_sel] == FREE) || (r_st[r_wr_sel] == WRITING);
        w_avail     = (r_st[r_rd_sel] == READY);
        w_wr_acc    = bus.wr_en & w_mem_ready;
        w_close     = w_wr_acc & bus.done;
        // Once truncated, the RAM keeps the first full bank of words.
        w_ram_we    = w_wr_acc & ~r_trunc[r_wr_sel];
        w_claim     = bus.rd_start & w_avail;
        w_release   = bus.rd_done & (r_st[r_rd_sel] == READING);
        w_rd_ok     = bus.rd_en & (r_st[r_rd_sel] == READING);
    end

    pkt_dpram #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH + 1)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ram_we),
        .i_waddr ({r_wr_sel, bus.wr_addr}),
        .i_wdata (bus.wr_data),
        .i_re    (w_rd_ok),
        .i_raddr ({r_rd_sel, bus.rd_addr}),
        .o_rdata (w_rd_data)
    );

    assign bus.mem_ready = w_mem_ready;
    assign bus.pkt_avail = w_avail;
    assign bus.pkt_len   = r_len[r_rd_sel];
    assign bus.pkt_trunc = r_trunc[r_rd_sel];
    assign bus.rd_data   = w_rd_data;
    assign bus.rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_packet_pingpong_mem.sv
// Directed bench for packet_pingpong_mem.
// Inputs change and outputs are sampled on the falling edge.
module tb_packet_pingpong_mem;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    packet_pingpong_mem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(9)) bus ();

    packet_pingpong_mem #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.done     = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_start = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_done  = 1'b0;
    endtask

    task automatic wr(input logic [8:0] a, input logic [63:0] d,
                      input logic dn);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.done    = dn;
        tick();
        bus.wr_en   = 1'b0;
        bus.done    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [8:0] a,
                      input logic [63:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
        chk({tag, "_vld"}, 64'(bus.rd_valid), 64'd1);
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic start();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
    endtask

    task automatic release_bank();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"},   64'(bus.mem_ready), 64'd1);
        chk({tag, "_avail"}, 64'(bus.pkt_avail), 64'd0);
        chk({tag, "_len"},   64'(bus.pkt_len),   64'd0);
        chk({tag, "_trunc"}, 64'(bus.pkt_trunc), 64'd0);
        chk({tag, "_vld"},   64'(bus.rd_valid),  64'd0);
        chk({tag, "_data"},  bus.rd_data,        64'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Reader strobes with nothing available.
        bus.rd_start = 1'b1;
        bus.rd_en    = 1'b1;
        bus.rd_done  = 1'b1;
        tick();
        idle();
        chk("idle_vld",   64'(bus.rd_valid),  64'd0);
        chk("idle_avail", 64'(bus.pkt_avail), 64'd0);
        chk("idle_rdy",   64'(bus.mem_ready), 64'd1);
        tick();
        chk("idle_vld2",  64'(bus.rd_valid),  64'd0);

        // 4-word packet into bank 0.
        wr(9'd0, 64'h11, 1'b0);
        chk("p4_avail0", 64'(bus.pkt_avail), 64'd0);
        wr(9'd1, 64'h22, 1'b0);
        wr(9'd2, 64'h33, 1'b0);
        wr(9'd3, 64'h44, 1'b1);
        chk("p4_avail", 64'(bus.pkt_avail), 64'd1);
        chk("p4_len",   64'(bus.pkt_len),   64'd4);
        chk("p4_rdy",   64'(bus.mem_ready), 64'd1);
        start();
        chk("p4_claim", 64'(bus.pkt_avail), 64'd0);
        rd("p4_w0", 9'd0, 64'h11);
        rd("p4_w1", 9'd1, 64'h22);
        rd("p4_w2", 9'd2, 64'h33);
        rd("p4_w3", 9'd3, 64'h44);
        tick();
        chk("p4_vld_off", 64'(bus.rd_valid), 64'd0);
        chk("p4_hold",    bus.rd_data,       64'h44);
        release_bank();
        chk("p4_free", 64'(bus.pkt_avail), 64'd0);

        // Three 2-word packets, reader idle: wr_sel and rd_sel both at bank 1.
        wr(9'd0, 64'hA1, 1'b0);
        wr(9'd1, 64'hA2, 1'b1);
        chk("bb_rdy1", 64'(bus.mem_ready), 64'd1);
        wr(9'd0, 64'hB1, 1'b0);
        wr(9'd1, 64'hB2, 1'b1);
        chk("bb_rdy2", 64'(bus.mem_ready), 64'd0);
        wr(9'd0, 64'hC1, 1'b0);
        wr(9'd1, 64'hC2, 1'b1);
        chk("bb_rdy3",  64'(bus.mem_ready), 64'd0);
        chk("bb_avail", 64'(bus.pkt_avail), 64'd1);
        chk("bb_lenA",  64'(bus.pkt_len),   64'd2);
        start();
        rd("bb_a0", 9'd0, 64'hA1);
        rd("bb_a1", 9'd1, 64'hA2);
        release_bank();
        chk("bb_rdy4",   64'(bus.mem_ready), 64'd1);
        chk("bb_avail2", 64'(bus.pkt_avail), 64'd1);
        chk("bb_lenB",   64'(bus.pkt_len),   64'd2);
        start();
        rd("bb_b0", 9'd0, 64'hB1);
        rd("bb_b1", 9'd1, 64'hB2);
        release_bank();
        chk("bb_empty", 64'(bus.pkt_avail), 64'd0);

        // Release of bank 0 coincides with done steering the writer to bank 0.
        wr(9'd0, 64'hD1, 1'b1);
        wr(9'd0, 64'hE1, 1'b1);
        chk("sim_full", 64'(bus.mem_ready), 64'd0);
        start();
        rd("sim_d0", 9'd0, 64'hD1);
        release_bank();
        chk("sim_rdy", 64'(bus.mem_ready), 64'd1);
        start();
        wr(9'd0, 64'hF1, 1'b0);
        wr(9'd1, 64'hF2, 1'b0);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 9'd2;
        bus.wr_data = 64'hF3;
        bus.done    = 1'b1;
        bus.rd_done = 1'b1;
        tick();
        idle();
        chk("sim_rdy2",  64'(bus.mem_ready), 64'd1);
        chk("sim_avail", 64'(bus.pkt_avail), 64'd1);
        chk("sim_len",   64'(bus.pkt_len),   64'd3);
        start();
        rd("sim_f0", 9'd0, 64'hF1);
        rd("sim_f2", 9'd2, 64'hF3);
        release_bank();

        // 513 words into bank 0: truncated at 512.
        for (int i = 0; i < 512; i++) begin
            wr(9'(i), {32'hC0DE0000, 32'(i)}, 1'b0);
        end
        chk("tr_rdy", 64'(bus.mem_ready), 64'd1);
        wr(9'd0, 64'hDEAD, 1'b1);
        chk("tr_avail", 64'(bus.pkt_avail), 64'd1);
        chk("tr_len",   64'(bus.pkt_len),   64'd512);
        chk("tr_flag",  64'(bus.pkt_trunc), 64'd1);
        start();
        rd("tr_w0",   9'd0,   64'hC0DE0000_00000000);
        rd("tr_w256", 9'd256, 64'hC0DE0000_00000100);
        rd("tr_w511", 9'd511, 64'hC0DE0000_000001FF);
        release_bank();
        chk("tr_clr", 64'(bus.pkt_trunc), 64'd0);

        // Reset in the middle of a 5-word packet.
        wr(9'd0, 64'h51, 1'b0);
        wr(9'd1, 64'h52, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wr(9'd0, 64'h77, 1'b1);
        chk("mid_avail", 64'(bus.pkt_avail), 64'd1);
        chk("mid_len",   64'(bus.pkt_len),   64'd1);
        start();
        rd("mid_w0", 9'd0, 64'h77);
        release_bank();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/packet_pingpong_mem.md
# packet_pingpong_mem

Two-bank packet buffer sitting directly downstream of the AXI-Stream snooper. Accepts the snooper's word writes and `done` strobe and stores each captured packet in one of two banks. Presents completed packets, strictly in arrival order, to the filter-side reader through a start/read/done handshake. Back-pressures the snooper through `mem_ready` when both banks are occupied.

## Interface
- `DATA_WIDTH`, 64, word width; matches the snooper's data width.
- `ADDR_WIDTH`, 9, word address width per bank; each bank holds 2^ADDR_WIDTH words.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_addr` in ADDR_WIDTH: snooper word address within the current write bank.
- `wr_data` in DATA_WIDTH: snooper write data.
- `wr_en` in 1: snooper write strobe.
- `done` in 1: marks the last word of a packet; only meaningful with `wr_en`.
- `mem_ready` out 1: the current write bank can accept words.
- `pkt_avail` out 1: the current read bank holds a complete packet not yet claimed.
- `pkt_len` out ADDR_WIDTH+1: word count of the current read bank's packet.
- `pkt_trunc` out 1: the current read bank's packet overflowed and was truncated.
- `rd_start` in 1: reader claims the available packet.
- `rd_addr` in ADDR_WIDTH: read word address.
- `rd_en` in 1: read strobe.
- `rd_data` out DATA_WIDTH: registered read data.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `rd_done` in 1: reader releases the bank.

## Operation
- Each bank has a 2-bit state: FREE, WRITING, READY, READING.
- Two pointers, `wr_sel` and `rd_sel`, select the write and read banks.
- `mem_ready` = state[wr_sel] ∈ {FREE, WRITING}. It is decoded from registered state, so there is no combinational path from `wr_en`.
- Write path, effective only when `wr_en & mem_ready`:
  - The word is written to RAM at {wr_sel, wr_addr}.
  - FREE→WRITING on the first word of a packet.
- Completing a packet (`wr_en & done & mem_ready`):
  - state[wr_sel]→READY.
  - len[wr_sel] = wr_addr+1, computed at ADDR_WIDTH+1 bits; the maximum is 2^ADDR_WIDTH.
  - `wr_sel` toggles unconditionally. If the new bank is not FREE, `mem_ready` drops until the reader frees it.
- `wr_en` while `mem_ready`=0: the word is dropped and no state changes.
- Truncation:
  - If a write lands at wr_addr = 2^ADDR_WIDTH−1 without `done`, set trunc[wr_sel].
  - Further non-`done` writes in that packet are dropped; the RAM keeps its full content.
  - The next `done` closes the packet with len = 2^ADDR_WIDTH.
  - The flag clears when the bank goes FREE→WRITING.
- Read path:
  - `pkt_avail` = (state[rd_sel]==READY).
  - `rd_start & pkt_avail`: READY→READING. `rd_start` at any other time is ignored.
  - `rd_en` is honoured only while state[rd_sel]==READING.
  - `rd_done` while READING: bank→FREE, trunc cleared, `rd_sel` toggles. `rd_done` in any other state is ignored.
- Ordering: both pointers alternate, so packets are delivered in arrival order.
- Simultaneous events:
  - `rd_done` on bank A and a `done` toggling `wr_sel` to A in the same cycle: A is FREE in the next cycle and `mem_ready` reasserts there.
  - A write to one bank and a read of the other in the same cycle never conflict.

## Timing
- Reset values: `mem_ready`=1, `pkt_avail`=0, `pkt_len`=0, `pkt_trunc`=0, `rd_valid`=0, `rd_data`=0.
- Reset effects: both banks FREE, both pointers 0, lengths 0. RAM contents are not cleared.
- Reset mid-packet discards all banks. The snooper is expected to be reset alongside.
- Write: the word is stored at the edge where `wr_en` is sampled. State updates at the same edge; `mem_ready` reflects the new state in the next cycle.
- Read latency: exactly 1 cycle. `rd_en` at cycle N gives `rd_data`/`rd_valid` at N+1.
- `rd_valid` deasserts the cycle after `rd_en` falls. When not valid, `rd_data` holds its last value.
- Minimum packet-to-reader latency: `done` at N, `pkt_avail`=1 at N+1, `rd_start` at N+1, first `rd_en` at N+2, data at N+3.
- `pkt_len`/`pkt_trunc` are stable from `pkt_avail` until `rd_done`.

## Structure
- Shared package `pkt_mem_pkg`:
  - bank state enum encoding: FREE=0, WRITING=1, READY=2, READING=3.
  - bank count constant `NUM_BANKS`=2.
- Sub-module `pkt_dpram`:
  - simple dual-port RAM, one write port and one registered read port.
  - depth 2^(ADDR_WIDTH+1); the bank select bit is the address MSB.
  - inferable as block RAM.
- Top level holds the bank state machine, pointers, length/trunc registers and `rd_valid` pipeline.

## Test plan
- 4-word packet, data 0x11..0x44, `done` on word 3 → `pkt_avail` next cycle, `pkt_len`=4. `rd_start`, then reads at addresses 0..3 return 0x11..0x44 one cycle later. `rd_done` → bank FREE.
- Three back-to-back 2-word packets, reader idle → packets 1 and 2 fill both banks. `mem_ready`=0 from the cycle after packet 2's `done`, and packet 3's writes are dropped. After `rd_done`, `mem_ready`=1 next cycle and the reader sees packet 2 with `pkt_len`=2.
- 513 words with ADDR_WIDTH=9, `done` on the last → `pkt_len`=512, `pkt_trunc`=1, word 511 intact.
- `rd_done` on bank 0 in the same cycle as `done` toggles `wr_sel` to 0 → `mem_ready`=1 the following cycle, with no lost packet.
- Assert `rst_n` low mid-packet (word 2 of 5) → all outputs at reset values. A following 1-word packet gives `pkt_len`=1 in bank 0.
- `rd_en`/`rd_start`/`rd_done` with `pkt_avail`=0 → no state change and `rd_valid` stays 0.
